// File: rtl/gaussian_blur_3x3_if.sv
// Frame-level bundle between gaussian_blur_3x3 and its SRAM1/SRAM2 neighbours.
// The bypass request bit exists only when GAUS_BYPASS_EN is defined.
interface gaussian_blur_3x3_if #(
  parameter int unsigned X_MAX = 5,
  parameter int unsigned Y_MAX = 5
);
  localparam int unsigned DXW = $clog2(X_MAX + 1);
  localparam int unsigned DYW = $clog2(Y_MAX + 1);
  localparam int unsigned AXW = $clog2(X_MAX) + 1;
  localparam int unsigned AYW = $clog2(Y_MAX) + 1;

  logic           new_trans;
  logic [DXW-1:0] max_x;
  logic [DYW-1:0] max_y;
`ifdef GAUS_BYPASS_EN
  logic           bypass;
`endif
  logic           read_SRAM1;
  logic [AXW-1:0] x_addr1;
  logic [AYW-1:0] y_addr1;
  logic [7:0]     SRAM1_in;
  logic           write_SRAM2;
  logic [AXW-1:0] x_addr2;
  logic [AYW-1:0] y_addr2;
  logic [7:0]     SRAM2_out;
  logic           gaus_sample_flag;
  logic           gaus_done;
  logic           busy;

  modport slave (
`ifdef GAUS_BYPASS_EN
    input  bypass,
`endif
    input  new_trans, max_x, max_y, SRAM1_in,
    output read_SRAM1, x_addr1, y_addr1, write_SRAM2, x_addr2, y_addr2,
           SRAM2_out, gaus_sample_flag, gaus_done, busy
  );

  modport master (
`ifdef GAUS_BYPASS_EN
    output bypass,
`endif
    output new_trans, max_x, max_y, SRAM1_in,
    input  read_SRAM1, x_addr1, y_addr1, write_SRAM2, x_addr2, y_addr2,
           SRAM2_out, gaus_sample_flag, gaus_done, busy
  );
endinterface

// File: rtl/gaussian_blur_3x3.sv
// 3x3 binomial blur with edge-replicate borders, SRAM1 -> SRAM2 in raster order.
// Optional GAUS_BYPASS_EN: per-frame bypass copies pixels unchanged.
module gaussian_blur_3x3 #(
  parameter int unsigned X_MAX = 5,
  parameter int unsigned Y_MAX = 5
) (
  input logic                clk,
  input logic                rst,
  gaussian_blur_3x3_if.slave bus
);
  localparam int unsigned AXW = $clog2(X_MAX) + 1;
  localparam int unsigned AYW = $clog2(Y_MAX) + 1;
  localparam int unsigned DXW = $clog2(X_MAX + 1);
  localparam int unsigned DYW = $clog2(Y_MAX + 1);
  localparam int unsigned CW  = (AXW > AYW) ? AXW : AYW;
  localparam int unsigned SW  = 12;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

  state_t         state;
  logic [DXW-1:0] mx;
  logic [DYW-1:0] my;
  logic [CW-1:0]  x, y;
  logic [1:0]     c, r, pend_c, pend_r;
  logic           pend, byp;
  logic [7:0]     win [3][3];

  logic           rd, wr, flag, done, busy_q;
  logic [AXW-1:0] xa1, xa2;
  logic [AYW-1:0] ya1, ya2;
  logic [7:0]     pix;

  logic           byp_in_c, last_rd_c, row_end_c;
  logic [1:0]     nc_c, nr_c, sc_c, sr_c;
  logic [CW-1:0]  lim_x_c, lim_y_c, nx_c, ny_c;
  logic [7:0]     tap [3][3];
  logic [SW-1:0]  sum_c;

`ifdef GAUS_BYPASS_EN
  assign byp_in_c = bus.bypass;
`else
  assign byp_in_c = 1'b0;
`endif

  // Offset code o: 0 -> p-1, 1 -> p, 2 -> p+1, clamped to [0, lim].
  function automatic logic [CW-1:0] clamp(input logic [CW-1:0] p, input logic [1:0] o,
                                          input logic [CW-1:0] lim);
    if (o == 2'd0) return (p == '0) ? '0 : p - CW'(1);
    if (o == 2'd2) return (p >= lim) ? lim : p + CW'(1);
    return p;
  endfunction

  // Read sequencing and next-pixel bookkeeping.
  always_comb begin
    lim_x_c   = CW'(mx) - CW'(1);
    lim_y_c   = CW'(my) - CW'(1);
    last_rd_c = byp || (c == 2'd2 && r == 2'd2);
    nc_c      = (r == 2'd2) ? c + 2'd1 : c;
    nr_c      = (r == 2'd2) ? 2'd0 : r + 2'd1;
    row_end_c = (x == lim_x_c);
    nx_c      = row_end_c ? '0 : x + CW'(1);
    ny_c      = row_end_c ? y + CW'(1) : y;
    sc_c      = byp ? 2'd1 : ((nx_c == '0) ? 2'd0 : 2'd2);
    sr_c      = byp ? 2'd1 : 2'd0;
  end

  // Kernel sum; the bottom-right tap is still in flight on SRAM1_in during DRAIN.
  always_comb begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        tap[i][j] = win[i][j];
    tap[2][2] = bus.SRAM1_in;
    sum_c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum_c = sum_c + (SW'(tap[i][j]) << ((i == 1 ? 1 : 0) + (j == 1 ? 1 : 0)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mx <= '0; my <= '0; x <= '0; y <= '0;
      c <= '0; r <= '0; pend_c <= '0; pend_r <= '0;
      pend <= 1'b0; byp <= 1'b0;
      rd <= 1'b0; wr <= 1'b0; flag <= 1'b0; done <= 1'b0; busy_q <= 1'b0;
      xa1 <= '0; ya1 <= '0; xa2 <= '0; ya2 <= '0; pix <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[i][j] <= '0;
    end else begin
      pend   <= rd;
      pend_c <= c;
      pend_r <= r;
      if (pend) win[pend_c][pend_r] <= bus.SRAM1_in;

      case (state)
        IDLE, DONE: begin
          if (bus.new_trans) begin
            mx  <= bus.max_x;
            my  <= bus.max_y;
            byp <= byp_in_c;
            x   <= '0;
            y   <= '0;
            if (bus.max_x == '0 || bus.max_y == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= FETCH;
              done   <= 1'b0;
              busy_q <= 1'b1;
              rd     <= 1'b1;
              xa1    <= '0;
              ya1    <= '0;
              c      <= byp_in_c ? 2'd1 : 2'd0;
              r      <= byp_in_c ? 2'd1 : 2'd0;
            end
          end
        end
        FETCH: begin
          if (last_rd_c) begin
            state <= DRAIN;
            rd    <= 1'b0;
          end else begin
            c   <= nc_c;
            r   <= nr_c;
            xa1 <= AXW'(clamp(x, nc_c, lim_x_c));
            ya1 <= AYW'(clamp(y, nr_c, lim_y_c));
          end
        end
        DRAIN: begin
          state <= WRITE;
          wr    <= 1'b1;
          flag  <= 1'b1;
          xa2   <= AXW'(x);
          ya2   <= AYW'(y);
          pix   <= byp ? bus.SRAM1_in : 8'((sum_c + SW'(8)) >> 4);
        end
        WRITE: begin
          wr   <= 1'b0;
          flag <= 1'b0;
          if (row_end_c && y == lim_y_c) begin
            state  <= DONE;
            done   <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state <= FETCH;
            x     <= nx_c;
            y     <= ny_c;
            rd    <= 1'b1;
            c     <= sc_c;
            r     <= sr_c;
            xa1   <= AXW'(clamp(nx_c, sc_c, lim_x_c));
            ya1   <= AYW'(clamp(ny_c, sr_c, lim_y_c));
            // Mid-row: slide the window so only the new right column is fetched.
            if (nx_c != '0) begin
              for (int j = 0; j < 3; j++) begin
                win[0][j] <= win[1][j];
                win[1][j] <= win[2][j];
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_SRAM1       = rd;
  assign bus.x_addr1          = xa1;
  assign bus.y_addr1          = ya1;
  assign bus.write_SRAM2      = wr;
  assign bus.x_addr2          = xa2;
  assign bus.y_addr2          = ya2;
  assign bus.SRAM2_out        = pix;
  assign bus.gaus_sample_flag = flag;
  assign bus.gaus_done        = done;
  assign bus.busy             = busy_q;
endmodule

// File: tb/tb_gaussian_blur_3x3.sv
// Directed bench for gaussian_blur_3x3: SRAM1 model, SRAM2 capture, hand-computed images.
module tb_gaussian_blur_3x3;
  localparam int unsigned X_MAX = 5;
  localparam int unsigned Y_MAX = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gaussian_blur_3x3_if #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) bus ();
  gaussian_blur_3x3 #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem     [Y_MAX][X_MAX];
  logic [7:0] img     [Y_MAX][X_MAX];
  logic [7:0] exp_img [Y_MAX][X_MAX];

  int checks = 0;
  int passed = 0;
  int first_rd, last_wr, done_cyc, nwr, nflag, flag_err, overlap, range_err, order_err, busy_err;

  // SRAM1: one-cycle read latency.
  always @(posedge clk)
    if (bus.read_SRAM1)
      bus.SRAM1_in <= (int'(bus.x_addr1) < X_MAX && int'(bus.y_addr1) < Y_MAX)
                      ? mem[bus.y_addr1][bus.x_addr1] : 8'hxx;

  task automatic check(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int yy = 0; yy < Y_MAX; yy++)
      for (int xx = 0; xx < X_MAX; xx++) begin
        mem[yy][xx]     = v;
        exp_img[yy][xx] = 8'd0;
      end
  endtask

  // Start a frame, watch it cycle by cycle; cycle 0 is the first cycle after new_trans.
  task automatic run_frame(input int w, input int h, input int nt_at);
    first_rd = -1; last_wr = -1; done_cyc = -1; nwr = 0; nflag = 0;
    flag_err = 0; overlap = 0; range_err = 0; order_err = 0; busy_err = 0;
    for (int yy = 0; yy < Y_MAX; yy++)
      for (int xx = 0; xx < X_MAX; xx++)
        img[yy][xx] = 8'hEE;
    @(negedge clk);
    bus.new_trans = 1'b1;
    bus.max_x = 3'(w);
    bus.max_y = 3'(h);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.new_trans = (cyc == nt_at);
      if (cyc == nt_at) begin
        bus.max_x = 3'd1;
        bus.max_y = 3'd1;
      end
      if (bus.read_SRAM1 && first_rd < 0) first_rd = cyc;
      if (bus.read_SRAM1 && (int'(bus.x_addr1) >= w || int'(bus.y_addr1) >= h)) range_err++;
      if (bus.read_SRAM1 && bus.write_SRAM2) overlap++;
      if (bus.gaus_sample_flag !== bus.write_SRAM2) flag_err++;
      if (bus.gaus_sample_flag) nflag++;
      if (!bus.gaus_done && bus.busy !== 1'b1) busy_err++;
      if (bus.gaus_done && bus.busy !== 1'b0) busy_err++;
      if (bus.write_SRAM2) begin
        if (w == 0 || int'(bus.x_addr2) != nwr % w || int'(bus.y_addr2) != nwr / w) order_err++;
        else img[bus.y_addr2][bus.x_addr2] = bus.SRAM2_out;
        nwr++;
        last_wr = cyc;
      end
      if (bus.gaus_done) begin
        done_cyc = cyc;
        break;
      end
    end
    bus.new_trans = 1'b0;
  endtask

  task automatic frame_checks(input string tag, input int w, input int h, input int exp_last);
    check({tag, ".writes"}, nwr, w * h);
    check({tag, ".flags"}, nflag, w * h);
    check({tag, ".flag_align"}, flag_err, 0);
    check({tag, ".rd_wr_overlap"}, overlap, 0);
    check({tag, ".rd_range"}, range_err, 0);
    check({tag, ".raster"}, order_err, 0);
    check({tag, ".busy"}, busy_err, 0);
    check({tag, ".first_read"}, first_rd, (w * h > 0) ? 0 : -1);
    check({tag, ".last_write"}, last_wr, exp_last);
    check({tag, ".done_cycle"}, done_cyc, exp_last + 1);
  endtask

  task automatic img_checks(input string tag, input int w, input int h);
    int bad;
    bad = 0;
    for (int yy = 0; yy < h; yy++)
      for (int xx = 0; xx < w; xx++)
        if (img[yy][xx] !== exp_img[yy][xx]) bad++;
    check({tag, ".pixel_mismatches"}, bad, 0);
  endtask

  initial begin
    bus.new_trans = 1'b0;
    bus.max_x = '0;
    bus.max_y = '0;
`ifdef GAUS_BYPASS_EN
    bus.bypass = 1'b0;
`endif
    fill(8'd0);
    repeat (3) @(negedge clk);
    check("reset.ctrl", {bus.read_SRAM1, bus.write_SRAM2, bus.gaus_sample_flag, bus.gaus_done, bus.busy}, 0);
    check("reset.pixel", bus.SRAM2_out, 0);
    rst = 1'b0;

    // Uniform 100: every output 100, 155-cycle frame.
    fill(8'd100);
    for (int yy = 0; yy < 5; yy++) for (int xx = 0; xx < 5; xx++) exp_img[yy][xx] = 8'd100;
    run_frame(5, 5, -1);
    frame_checks("uniform", 5, 5, 154);
    img_checks("uniform", 5, 5);

    // Centre impulse 160.
    fill(8'd0);
    mem[2][2] = 8'd160;
    exp_img = '{'{0, 0, 0, 0, 0}, '{0, 10, 20, 10, 0}, '{0, 20, 40, 20, 0},
                '{0, 10, 20, 10, 0}, '{0, 0, 0, 0, 0}};
    run_frame(5, 5, -1);
    frame_checks("impulse", 5, 5, 154);
    img_checks("impulse", 5, 5);
    check("impulse.centre", img[2][2], 40);
    check("impulse.left", img[2][1], 20);
    check("impulse.diag", img[3][3], 10);

    // Corner impulse exercises clamping on both axes.
    fill(8'd0);
    mem[0][0] = 8'd16;
    exp_img[0][0] = 8'd9; exp_img[0][1] = 8'd3; exp_img[1][0] = 8'd3; exp_img[1][1] = 8'd1;
    run_frame(5, 5, -1);
    img_checks("corner", 5, 5);
    check("corner.00", img[0][0], 9);
    check("corner.10", img[0][1], 3);
    check("corner.11", img[1][1], 1);

    // Rounding half-up.
    fill(8'd0);
    mem[2][2] = 8'd1;
    run_frame(5, 5, -1);
    check("round1.centre", img[2][2], 0);
    img_checks("round1", 5, 5);
    fill(8'd0);
    mem[2][2] = 8'd2;
    exp_img[2][2] = 8'd1;
    run_frame(5, 5, -1);
    check("round2.centre", img[2][2], 1);
    img_checks("round2", 5, 5);

    // 1x1 frame: every tap replicates the single pixel.
    fill(8'd77);
    exp_img[0][0] = 8'd77;
    run_frame(1, 1, -1);
    frame_checks("one_by_one", 1, 1, 10);
    check("one_by_one.pixel", img[0][0], 77);

    // 1x3 column: only vertical detail survives.
    fill(8'd0);
    mem[0][0] = 8'd16; mem[1][0] = 8'd32; mem[2][0] = 8'd48;
    exp_img[0][0] = 8'd20; exp_img[1][0] = 8'd32; exp_img[2][0] = 8'd44;
    run_frame(1, 3, -1);
    frame_checks("column", 1, 3, 32);
    img_checks("column", 1, 3);

    // Reset 40 cycles into a frame.
    fill(8'd60);
    @(negedge clk);
    bus.new_trans = 1'b1; bus.max_x = 3'd5; bus.max_y = 3'd5;
    @(negedge clk);
    bus.new_trans = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.ctrl", {bus.read_SRAM1, bus.write_SRAM2, bus.gaus_sample_flag, bus.gaus_done, bus.busy}, 0);
    check("abort.pixel", bus.SRAM2_out, 0);
    nwr = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.write_SRAM2 || bus.read_SRAM1 || bus.gaus_done) nwr++;
    end
    check("abort.quiet", nwr, 0);

    // Fresh frame after abort; a new_trans mid-frame must be ignored.
    fill(8'd200);
    for (int yy = 0; yy < 5; yy++) for (int xx = 0; xx < 5; xx++) exp_img[yy][xx] = 8'd200;
    run_frame(5, 5, 50);
    frame_checks("busy_nt", 5, 5, 154);
    img_checks("busy_nt", 5, 5);

    // Zero width: done immediately with no traffic.
    run_frame(0, 5, -1);
    frame_checks("zero_dim", 0, 5, -1);

`ifdef GAUS_BYPASS_EN
    // Bypass: ramp copied unchanged, 3 cycles per pixel.
    for (int yy = 0; yy < 5; yy++)
      for (int xx = 0; xx < 5; xx++) begin
        mem[yy][xx]     = 8'(10 * yy + xx);
        exp_img[yy][xx] = 8'(10 * yy + xx);
      end
    bus.bypass = 1'b1;
    run_frame(5, 5, -1);
    bus.bypass = 1'b0;
    frame_checks("bypass", 5, 5, 74);
    img_checks("bypass", 5, 5);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
